// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant, its binary index,
// and IDLE/BUSY ownership sequencing (release on done, request drop or hold timeout).
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic       win_valid;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       drop;
    logic       forced;

    // Rotating priority search: first set request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign drop   = ~req[idx_q];
    assign forced = HOLD_EN && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (win_valid) begin
                    state_d = BUSY;
                    grant_d = 8'd1 << win_idx;
                    idx_d   = win_idx;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (done || drop || forced) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_d     = idx_q + 3'd1;
                    // done and a request drop take precedence over the forced release
                    timeout_d = forced && !done && !drop;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == BUSY);
    assign timeout     = timeout_q;

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter for 8 requesters sharing one downstream resource.
- Produces a registered one-hot grant and its 3-bit encoded index. The index uses the same one-hot to binary mapping as the lab decoder: bit i maps to i.
- Sequences ownership through an IDLE/BUSY state machine: release on done, on request drop, or on a hold-timeout.
- Sits between requester logic and the shared datapath; grant_idx drives the datapath select.

Parameters:
- MAX_HOLD, 16: maximum consecutive BUSY cycles per grant. 0 disables the timeout. Legal range is 0..255; the hold counter is 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i is requester i. May be any pattern, not necessarily one-hot.
- done  input  1  owner signals completion. Sampled only in BUSY.
- grant  output  8  one-hot grant, registered; all zeros when no owner.
- grant_idx  output  3  binary index of the set grant bit; holds the last owner's index while idle.
- grant_valid  output  1  high while in BUSY.
- timeout  output  1  one-cycle pulse, asserted the cycle after a forced release.

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0, hold_cnt=0, ptr=3'd0.
  - ptr is the highest-priority index.
  - Reset mid-BUSY drops the grant immediately, without waiting for a clock edge.
- Arbitration (IDLE only):
  - Search req starting at ptr, ascending with wrap 7 to 0.
  - The first set bit k wins.
  - Example: ptr=5, req=8'b0010_0011 wins k=5; ptr=6 with the same req wins k=0.
- IDLE, req==0: stay IDLE; outputs unchanged except grant=0 and grant_valid=0.
- IDLE, req!=0: at the next edge state=BUSY, grant=1<<k, grant_idx=k, grant_valid=1, hold_cnt=0.
  - Latency is 1 cycle from req sampled to grant visible.
- BUSY, each edge:
  - Release when done=1, or when req[grant_idx]=0 (request dropped).
  - Release when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (forced).
  - Otherwise hold_cnt increments.
- Release effects at that edge:
  - state=IDLE, grant=0, grant_valid=0.
  - ptr=grant_idx+1, mod 8 (7 wraps to 0).
  - grant_idx holds its value.
  - timeout=1 only if the release was forced and neither done nor a request drop occurred in that cycle.
  - done and a drop take precedence; timeout clears the following cycle.
- Mandatory gap: after any release, IDLE lasts at least one cycle (grant_valid=0) before the next grant. Back-to-back grants are therefore spaced by 1 idle cycle.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,2,...,7,0. No requester waits more than 7 ownership periods.
- Changes to req bits other than the owner's while BUSY are ignored until IDLE.
- X on req: grant behaviour is undefined; the bench must not drive X after reset.
- Invariants, checked every cycle:
  - grant is one-hot or zero.
  - grant_valid == (grant!=0).
  - When grant_valid=1, grant == 1<<grant_idx.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> grant=0, grant_valid=0, grant_idx=0, timeout=0 throughout.
- Single requester: req=8'h08 -> after 1 cycle grant=8'h08, grant_idx=3; pulse done -> next cycle grant=0; 1 idle cycle; re-grant grant_idx=3.
- Rotation:
  - Stimulus: req=8'hFF held; done pulsed 2 cycles after each grant.
  - Required: grant_idx sequence 0,1,...,7,0; each grant separated by exactly 1 idle cycle.
- Wrap/priority:
  - Setup: make requester 6 the owner, so ptr=7 after its release.
  - Stimulus: req=8'b0100_0001, wait for release.
  - Required: next grant is idx 0, not 6.
- Timeout:
  - Setup: MAX_HOLD=4, req=8'h02 held, done=0.
  - Required: grant_valid high exactly 4 cycles; timeout=1 for 1 cycle after release; re-grant idx 1 after the idle cycle.
  - Also check that done asserted on the 4th cycle gives timeout=0.
- Async reset mid-BUSY: assert rst between edges while grant=8'h10 -> grant=0 and grant_valid=0 immediately; after deassert with req=8'h10, the grant is re-issued with ptr reset to 0.
